// File: rtl/fir_tdm_mc_if.sv
// Bus bundle for fir_tdm_mc: sample stream in, coefficient load port,
// filtered sample strobe out, and status pulses.
//   master : sample source / coefficient writer / result consumer
//   slave  : the filter itself
interface fir_tdm_mc_if #(
  parameter int unsigned N      = 39,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NCH    = 2
) ();
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned K_W  = $clog2(N);

  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic [CH_W-1:0]   s_tchan;
  logic              coef_wr;
  logic [K_W-1:0]    coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_busy;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic [CH_W-1:0]   m_tchan;
  logic              sat;
  logic              chan_err;

  modport master (
    output s_tvalid, s_tdata, s_tchan, coef_wr, coef_addr, coef_data,
    input  s_tready, coef_busy, m_tvalid, m_tdata, m_tchan, sat, chan_err
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tchan, coef_wr, coef_addr, coef_data,
    output s_tready, coef_busy, m_tvalid, m_tdata, m_tchan, sat, chan_err
  );
endinterface

// File: rtl/fir_tdm_mc.sv
// Time-multiplexed multi-channel FIR: one MAC shared by NCH channels, each
// with an N-deep sample history, one shared runtime-loadable coefficient set.
// Output is rounded half-up, shifted by OUT_SHIFT and saturated to DATA_W.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fir_tdm_mc_if.slave (s_* sample in with ready, coef_* load
//            port with busy, m_* result strobe, sat, chan_err)
module fir_tdm_mc #(
  parameter int unsigned N         = 39,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NCH       = 2,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  fir_tdm_mc_if.slave  bus
);
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned K_W    = $clog2(N);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(N);
  localparam int unsigned RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX  = (RND_W'(1) << (DATA_W - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] SAT_MIN  = -(RND_W'(1) << (DATA_W - 1));
  localparam logic [DATA_W-1:0]       OUT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] hist [NCH][N];
  logic signed [COEF_W-1:0] coef [N];
  logic [CH_W-1:0]          ch;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;

  logic                     chan_ok_c;
  logic                     coef_ok_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [RND_W-1:0]  rnd_c;
  logic signed [RND_W-1:0]  shr_c;

  // Range checks widened by one bit so a full-range index compares cleanly
  assign chan_ok_c = {1'b0, bus.s_tchan}   < (CH_W + 1)'(NCH);
  assign coef_ok_c = {1'b0, bus.coef_addr} < (K_W + 1)'(N);

  // Shared MAC product and output rounding path
  assign prod_c = hist[ch][k] * coef[k];
  assign rnd_c  = RND_W'(acc) + RND_HALF;
  assign shr_c  = rnd_c >>> OUT_SHIFT;

  // Control FSM, histories, coefficients and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ch            <= '0;
      k             <= '0;
      acc           <= '0;
      bus.s_tready  <= 1'b1;
      bus.coef_busy <= 1'b0;
      bus.m_tvalid  <= 1'b0;
      bus.m_tdata   <= '0;
      bus.m_tchan   <= '0;
      bus.sat       <= 1'b0;
      bus.chan_err  <= 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < N; i++)
          hist[c][i] <= '0;
      for (int i = 0; i < N; i++)
        coef[i] <= '0;
    end else begin
      bus.m_tvalid <= 1'b0;
      bus.chan_err <= 1'b0;
      case (state)
        IDLE: begin
          // A write landing with an accepted sample is seen by that sample's MAC
          if (bus.coef_wr && coef_ok_c)
            coef[bus.coef_addr] <= bus.coef_data;
          if (bus.s_tvalid) begin
            if (chan_ok_c) begin
              hist[bus.s_tchan][0] <= bus.s_tdata;
              for (int i = 1; i < N; i++)
                hist[bus.s_tchan][i] <= hist[bus.s_tchan][i-1];
              ch            <= bus.s_tchan;
              acc           <= '0;
              k             <= '0;
              bus.s_tready  <= 1'b0;
              bus.coef_busy <= 1'b1;
              state         <= MAC;
            end else begin
              bus.chan_err <= 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod_c);
          k   <= k + K_W'(1);
          if (k == K_W'(N - 1))
            state <= OUT;
        end
        OUT: begin
          bus.m_tvalid <= 1'b1;
          bus.m_tchan  <= ch;
          if (shr_c > SAT_MAX) begin
            bus.m_tdata <= OUT_MAX;
            bus.sat     <= 1'b1;
          end else if (shr_c < SAT_MIN) begin
            bus.m_tdata <= OUT_MIN;
            bus.sat     <= 1'b1;
          end else begin
            bus.m_tdata <= DATA_W'(shr_c);
            bus.sat     <= 1'b0;
          end
          bus.s_tready  <= 1'b1;
          bus.coef_busy <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tdm_mc.sv
// Bench for fir_tdm_mc: directed scenarios with literal results plus a random
// phase, all checked every cycle against a sum-of-products reference model.
module tb_fir_tdm_mc;
  localparam int unsigned N         = 39;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned NCH       = 3;
  localparam int unsigned OUT_SHIFT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fir_tdm_mc_if #(.N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .NCH(NCH)) bus ();

  fir_tdm_mc #(
    .N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .NCH(NCH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int data;
    int chan;
    int satv;
  } exp_t;

  int   nchk = 0;
  int   nerr = 0;
  exp_t expq[$];
  int   m_hist [NCH][N];
  int   m_coef [N];
  int   ecnt;
  int   ready_at;
  int   cherr_edge;
  bit   acc_flag;
  bit   chk_en = 1'b0;
  int   held_data, held_chan, held_sat;
  int   obs_cnt = 0;
  int   obs_data, obs_chan, obs_sat;
  int   cherr_cnt = 0;

  task automatic check(input string name, input longint act, input longint want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void model_reset();
    ecnt       = 0;
    ready_at   = 0;
    cherr_edge = -1;
    expq.delete();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < N; i++)
        m_hist[c][i] = 0;
    for (int i = 0; i < N; i++)
      m_coef[i] = 0;
    held_data = 0;
    held_chan = 0;
    held_sat  = 0;
  endfunction

  // Reference: per edge, decide acceptance from the block's busy window and
  // compute the whole filter output at once as a plain dot product.
  task automatic model_edge();
    longint sum;
    longint r;
    int     c;
    int     sv;
    exp_t   e;
    ecnt++;
    acc_flag = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (ecnt < ready_at) return;
    if (bus.coef_wr && int'(bus.coef_addr) < int'(N))
      m_coef[int'(bus.coef_addr)] = sx16(bus.coef_data);
    if (!bus.s_tvalid) return;
    acc_flag = 1'b1;
    c = int'(bus.s_tchan);
    if (c >= int'(NCH)) begin
      cherr_edge = ecnt;
      return;
    end
    for (int i = N - 1; i > 0; i--)
      m_hist[c][i] = m_hist[c][i-1];
    m_hist[c][0] = sx16(bus.s_tdata);
    sum = 0;
    for (int i = 0; i < N; i++)
      sum += longint'(m_hist[c][i]) * longint'(m_coef[i]);
    r  = (sum + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    sv = 0;
    if (r > 32767) begin
      r  = 32767;
      sv = 1;
    end else if (r < -32768) begin
      r  = -32768;
      sv = 1;
    end
    e.edge_no = ecnt + N + 1;
    e.data    = int'(r) & 32'hFFFF;
    e.chan    = c;
    e.satv    = sv;
    expq.push_back(e);
    ready_at = ecnt + N + 2;
  endtask

  // Compare process: every output against the model, every cycle
  always @(negedge clk) begin
    bit etv;
    bit rdy;
    if (chk_en) begin
      etv = (expq.size() > 0) && (expq[0].edge_no == ecnt);
      rdy = (ecnt + 1 >= ready_at);
      if (etv) begin
        held_data = expq[0].data;
        held_chan = expq[0].chan;
        held_sat  = expq[0].satv;
        void'(expq.pop_front());
      end
      check("m_tvalid", bus.m_tvalid, etv);
      check("s_tready", bus.s_tready, rdy);
      check("coef_busy", bus.coef_busy, !rdy);
      check("chan_err", bus.chan_err, cherr_edge == ecnt);
      check("m_tdata", bus.m_tdata, held_data);
      check("m_tchan", bus.m_tchan, held_chan);
      check("sat", bus.sat, held_sat);
      if (bus.m_tvalid) begin
        obs_cnt++;
        obs_data = int'(bus.m_tdata);
        obs_chan = int'(bus.m_tchan);
        obs_sat  = int'(bus.sat);
      end
      if (bus.chan_err) cherr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wr_coef(input int addr, input logic [15:0] data);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 6'(addr);
    bus.coef_data = data;
    step();
    bus.coef_wr = 1'b0;
  endtask

  task automatic send(input int chan, input logic [15:0] data);
    int i;
    bus.s_tvalid = 1'b1;
    bus.s_tchan  = 2'(chan);
    bus.s_tdata  = data;
    i = 0;
    do begin
      step();
      i++;
    end while (!acc_flag && i < 200);
    if (!acc_flag) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: got no acceptance expected one within 200 cycles");
    end
    bus.s_tvalid = 1'b0;
    bus.coef_wr  = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int c0;
    int i;
    c0 = obs_cnt;
    i  = 0;
    while (obs_cnt == c0 && i < int'(N) + 6) begin
      step();
      i++;
    end
    if (obs_cnt == c0) begin
      nchk++;
      nerr++;
      $display("FAIL %s_timeout: got no m_tvalid expected one within %0d cycles", name, N + 6);
    end
  endtask

  task automatic expect_lit(input string name, input logic [15:0] data,
                            input int chan, input int satv);
    wait_strobe(name);
    check({name, "_data"}, obs_data, int'(data));
    check({name, "_chan"}, obs_chan, chan);
    check({name, "_sat"}, obs_sat, satv);
  endtask

  task automatic load_lp();
    logic [15:0] v;
    for (int i = 0; i < 20; i++) begin
      if (i == 19)      v = 16'h39FB;
      else if (i == 18) v = 16'h2835;
      else              v = 16'($urandom_range(0, 16'h3000)) - 16'h1000;
      wr_coef(i, v);
      wr_coef(38 - i, v);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int e0;
    int acc_n;
    bus.s_tvalid  = 1'b0;
    bus.s_tdata   = '0;
    bus.s_tchan   = '0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    #2;
    do_reset();

    // Identity through tap 0
    wr_coef(0, 16'h4000);
    send(0, 16'h1000); expect_lit("id_1000", 16'h0800, 0, 0);
    send(0, 16'h2000); expect_lit("id_2000", 16'h1000, 0, 0);
    send(0, 16'hF000); expect_lit("id_F000", 16'hF800, 0, 0);
    // Coefficient write in the accepting cycle is used by that sample
    bus.coef_wr = 1'b1; bus.coef_addr = 6'd0; bus.coef_data = 16'h2000;
    send(0, 16'h1000); expect_lit("wr_same_cycle", 16'h0400, 0, 0);

    // Writes while busy or out of range are dropped
    send(0, 16'h1000);
    repeat (5) step();
    bus.coef_wr = 1'b1; bus.coef_addr = 6'd0; bus.coef_data = 16'h7FFF;
    repeat (3) step();
    bus.coef_wr = 1'b0;
    expect_lit("busy_inflight", 16'h0400, 0, 0);
    wr_coef(39, 16'h7FFF);
    send(0, 16'h1000); expect_lit("busy_readback", 16'h0400, 0, 0);

    // Impulse response on channel 1
    do_reset();
    load_lp();
    for (int n = 0; n < 39; n++) begin
      send(1, (n == 0) ? 16'h7FFF : 16'h0000);
      if (n == 18 || n == 20) expect_lit("imp_tap18_20", 16'h2835, 1, 0);
      else if (n == 19)       expect_lit("imp_tap19", 16'h39FB, 1, 0);
      else                    wait_strobe("imp");
    end

    // Channel isolation
    do_reset();
    load_lp();
    for (int n = 0; n < 39; n++) begin
      send(0, (n == 0) ? 16'h7FFF : 16'h0000);
      if (n == 19) expect_lit("iso_ch0_tap19", 16'h39FB, 0, 0);
      else         wait_strobe("iso_ch0");
      send(1, 16'h0000);
      expect_lit("iso_ch1_zero", 16'h0000, 1, 0);
    end

    // Saturation both directions
    do_reset();
    for (int i = 0; i < 39; i++) wr_coef(i, 16'h7FFF);
    for (int n = 0; n < 39; n++) begin
      send(0, 16'h7FFF);
      if (n == 38) expect_lit("sat_pos", 16'h7FFF, 0, 1);
      else         wait_strobe("sat_pos_fill");
    end
    for (int n = 0; n < 39; n++) begin
      send(0, 16'h8000);
      if (n == 38) expect_lit("sat_neg", 16'h8000, 0, 1);
      else         wait_strobe("sat_neg_fill");
    end

    // Continuous s_tvalid: one acceptance per N+2 cycles
    acc_n = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tchan  = 2'd0;
    repeat (3 * (N + 2)) begin
      bus.s_tdata = 16'($urandom);
      if (bus.s_tready) acc_n++;
      step();
    end
    bus.s_tvalid = 1'b0;
    check("accept_count", acc_n, 3);
    repeat (N + 4) step();

    // Invalid channel: chan_err pulse, no result strobe
    c0 = obs_cnt;
    e0 = cherr_cnt;
    send(3, 16'h1234);
    repeat (N + 4) step();
    check("chan_err_count", cherr_cnt - e0, 1);
    check("chan_err_no_strobe", obs_cnt - c0, 0);

    // Reset in the middle of MAC: no strobe, then zero-history response
    send(0, 16'h7FFF);
    repeat (10) step();
    c0 = obs_cnt;
    do_reset();
    repeat (N + 4) step();
    check("rst_no_strobe", obs_cnt - c0, 0);
    wr_coef(0, 16'h4000);
    wr_coef(1, 16'h2000);
    send(0, 16'h7FFF); expect_lit("rst_fresh", 16'h4000, 0, 0);

    // Random traffic against the model
    repeat (4000) begin
      bus.s_tvalid  = ($urandom_range(0, 9) < 6);
      bus.s_tchan   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.s_tdata   = 16'($urandom);
      bus.coef_wr   = ($urandom_range(0, 9) < 2);
      bus.coef_addr = 6'($urandom_range(0, 63));
      bus.coef_data = 16'($urandom);
      step();
    end
    bus.s_tvalid = 1'b0;
    bus.coef_wr  = 1'b0;
    repeat (N + 4) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
